// File: rtl/dynamixel_write_scheduler.sv
// dynamixel_write_scheduler
//   Shares one Dynamixel sync-write frame generator between a periodic goal
//   stream (goal_value -> goal_address every period_clocks) and a one-shot
//   config channel. A grant registers address/value1..4, pulses send, and then
//   holds everything frozen for the frame plus guard time.
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   enable              runs the goal tick counter
//   goal_value[127:0]   {value4,value3,value2,value1} for goal frames
//   cfg_req             config write request (level)
//   cfg_address[15:0]   config control-table address
//   cfg_value[127:0]    {value4,value3,value2,value1} for config frames
//   cfg_ack             one-cycle grant pulse for the config channel
//   send                one-cycle start pulse to the frame generator
//   address, value1..4  frame contents, stable until the next grant
//   busy                high while a frame (plus guard) is in progress
//   goal_sent           one-cycle pulse alongside send for goal frames
//   overrun_count[7:0]  goal ticks dropped, saturating at 255
module dynamixel_write_scheduler #(
  parameter int unsigned clocks_per_bit = 1,
  parameter int unsigned goal_address   = 116,
  parameter int unsigned period_clocks  = 100000,
  parameter int unsigned guard_clocks   = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic [127:0] goal_value,
  input  logic         cfg_req,
  input  logic [15:0]  cfg_address,
  input  logic [127:0] cfg_value,
  output logic         cfg_ack,
  output logic         send,
  output logic [15:0]  address,
  output logic [31:0]  value1,
  output logic [31:0]  value2,
  output logic [31:0]  value3,
  output logic [31:0]  value4,
  output logic         busy,
  output logic         goal_sent,
  output logic [7:0]   overrun_count
);

  localparam int unsigned frame_clocks = 34 * 10 * clocks_per_bit + guard_clocks;
  localparam int unsigned tick_w       = $clog2(period_clocks);
  localparam int unsigned wait_w       = $clog2(frame_clocks + 1);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {SRC_GOAL, SRC_CFG} src_t;

  state_t              state, state_next;
  src_t                last_grant;
  logic [tick_w-1:0]   tick_cnt;
  logic [wait_w-1:0]   wait_cnt;
  logic                goal_pending;
  logic                tick_wrap;
  logic                grant_cfg, grant_goal;

  assign tick_wrap = enable && (tick_cnt == tick_w'(period_clocks - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    grant_cfg  = 1'b0;
    grant_goal = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_req && goal_pending) begin
          if (last_grant == SRC_CFG) grant_goal = 1'b1;
          else                       grant_cfg  = 1'b1;
        end else if (cfg_req) begin
          grant_cfg = 1'b1;
        end else if (goal_pending) begin
          grant_goal = 1'b1;
        end
        if (grant_cfg || grant_goal) state_next = WAIT;
      end
      WAIT: begin
        // The send cycle is WAIT count 0; frame_clocks more cycles follow it.
        if (wait_cnt == wait_w'(frame_clocks)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  wait_cnt <= '0;
    else if (state == WAIT && state_next == WAIT) wait_cnt <= wait_cnt + wait_w'(1);
    else                                        wait_cnt <= '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt      <= '0;
      goal_pending  <= 1'b0;
      overrun_count <= '0;
    end else begin
      if (!enable || tick_wrap) tick_cnt <= '0;
      else                      tick_cnt <= tick_cnt + tick_w'(1);

      // A wrap coinciding with a goal grant re-arms pending for the next frame.
      if (!enable)         goal_pending <= 1'b0;
      else if (tick_wrap)  goal_pending <= 1'b1;
      else if (grant_goal) goal_pending <= 1'b0;

      if (tick_wrap && goal_pending && !grant_goal && overrun_count != '1)
        overrun_count <= overrun_count + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      send       <= 1'b0;
      cfg_ack    <= 1'b0;
      goal_sent  <= 1'b0;
      address    <= '0;
      value1     <= '0;
      value2     <= '0;
      value3     <= '0;
      value4     <= '0;
      last_grant <= SRC_GOAL;
    end else begin
      send      <= grant_cfg || grant_goal;
      cfg_ack   <= grant_cfg;
      goal_sent <= grant_goal;
      if (grant_cfg) begin
        address    <= cfg_address;
        {value4, value3, value2, value1} <= cfg_value;
        last_grant <= SRC_CFG;
      end else if (grant_goal) begin
        address    <= 16'(goal_address);
        {value4, value3, value2, value1} <= goal_value;
        last_grant <= SRC_GOAL;
      end
    end
  end

endmodule

// File: tb/tb_dynamixel_write_scheduler.sv
module tb_dynamixel_write_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         en_a, en_b;
  logic [127:0] gv_a, gv_b;
  logic         cfg_req_a, cfg_req_b;
  logic [15:0]  cfg_addr_a, cfg_addr_b;
  logic [127:0] cfg_val_a, cfg_val_b;

  logic         a_cfg_ack, a_send, a_busy, a_goal_sent;
  logic [15:0]  a_address;
  logic [31:0]  a_v1, a_v2, a_v3, a_v4;
  logic [7:0]   a_overrun;
  logic         b_cfg_ack, b_send, b_busy, b_goal_sent;
  logic [15:0]  b_address;
  logic [31:0]  b_v1, b_v2, b_v3, b_v4;
  logic [7:0]   b_overrun;

  dynamixel_write_scheduler #(
    .clocks_per_bit(1), .goal_address(116), .period_clocks(1000), .guard_clocks(4)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(en_a), .goal_value(gv_a),
    .cfg_req(cfg_req_a), .cfg_address(cfg_addr_a), .cfg_value(cfg_val_a),
    .cfg_ack(a_cfg_ack), .send(a_send), .address(a_address),
    .value1(a_v1), .value2(a_v2), .value3(a_v3), .value4(a_v4),
    .busy(a_busy), .goal_sent(a_goal_sent), .overrun_count(a_overrun)
  );

  dynamixel_write_scheduler #(
    .clocks_per_bit(1), .goal_address(116), .period_clocks(20), .guard_clocks(4)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(en_b), .goal_value(gv_b),
    .cfg_req(cfg_req_b), .cfg_address(cfg_addr_b), .cfg_value(cfg_val_b),
    .cfg_ack(b_cfg_ack), .send(b_send), .address(b_address),
    .value1(b_v1), .value2(b_v2), .value3(b_v3), .value4(b_v4),
    .busy(b_busy), .goal_sent(b_goal_sent), .overrun_count(b_overrun)
  );

  typedef struct {
    logic [15:0]  addr;
    logic [127:0] val;
    logic         is_cfg;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  localparam logic [127:0] G1 = 128'h0000_0400_0000_0300_0000_0200_0000_0100;
  localparam logic [127:0] G2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] G3 = 128'hdead_beef_0000_0001_cafe_f00d_0000_0002;
  localparam logic [127:0] G4 = 128'h0000_0fff_0000_0800_0000_0001_ffff_ffff;

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps at least once, then until dut_a sends or the budget runs out.
  task automatic wait_send_a(input int max, output int at);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (a_send !== 1'b1 && n < max);
    at = cyc;
    chk("send_seen", a_send, 1'b1);
  endtask

  task automatic check_frame_a(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_address"}, a_address, e.addr);
      chk({tag, "_values"}, {a_v4, a_v3, a_v2, a_v1}, e.val);
      chk({tag, "_cfg_ack"}, a_cfg_ack, e.is_cfg);
      chk({tag, "_goal_sent"}, a_goal_sent, !e.is_cfg);
      chk({tag, "_busy"}, a_busy, 1'b1);
    end
  endtask

  initial begin
    int t, n, nsend, frame_bad, frozen_bad, dec_bad, late_sends;
    logic [7:0]   ov_mid, ov_prev;
    logic [127:0] held_val;
    logic [15:0]  held_addr;

    reset = 1'b1;
    en_a = 1'b0; gv_a = '0; cfg_req_a = 1'b0; cfg_addr_a = '0; cfg_val_a = '0;
    en_b = 1'b0; gv_b = '0; cfg_req_b = 1'b0; cfg_addr_b = '0; cfg_val_b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_send", a_send, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_cfg_ack", a_cfg_ack, 1'b0);
    chk("rst_goal_sent", a_goal_sent, 1'b0);
    chk("rst_frame", {a_address, a_v4, a_v3, a_v2, a_v1}, '0);
    chk("rst_overrun", a_overrun, 8'd0);

    // Goal tick wraps at edge 1000; cfg arrives with it, giving a tie after reset.
    reset = 1'b0; en_a = 1'b1; gv_a = G1; cyc = 0;
    repeat (1000) step();
    cfg_req_a = 1'b1; cfg_addr_a = 16'd64; cfg_val_a = {96'h0, 32'h1};
    sb.push_back('{16'd64, {96'h0, 32'h1}, 1'b1});
    sb.push_back('{16'd116, G1, 1'b0});
    wait_send_a(5, t);
    chk("tie_cfg_at", t, 1001);
    check_frame_a("tie_cfg");
    cfg_req_a = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 2000) begin
      n++;
      step();
    end
    chk("busy_len", n, 345);
    wait_send_a(10, t);
    chk("tie_goal_at", t, 1347);
    check_frame_a("tie_goal");

    // Periodic stream: goal_value sampled at the grant edge.
    gv_a = G2;
    sb.push_back('{16'd116, G2, 1'b0});
    wait_send_a(1000, t);
    chk("goal2_at", t, 2001);
    check_frame_a("goal2");
    gv_a = G3;
    sb.push_back('{16'd116, G3, 1'b0});
    wait_send_a(1100, t);
    chk("period_spacing", t - 2001, 1000);
    check_frame_a("goal3");

    // cfg raised 10 cycles into WAIT waits for the first IDLE edge.
    repeat (10) step();
    cfg_req_a = 1'b1; cfg_addr_a = 16'h0018; cfg_val_a = 128'h0a0b_0c0d;
    sb.push_back('{16'h0018, 128'h0a0b_0c0d, 1'b1});
    wait_send_a(400, t);
    chk("late_cfg_at", t, 3347);
    check_frame_a("late_cfg");
    cfg_req_a = 1'b0;

    // Lone cfg, then a tie during its WAIT: last_grant=CFG so GOAL wins.
    while (cyc < 3800) step();
    cfg_req_a = 1'b1; cfg_addr_a = 16'h0040; cfg_val_a = 128'h5;
    sb.push_back('{16'h0040, 128'h5, 1'b1});
    wait_send_a(10, t);
    chk("lone_cfg_at", t, 3801);
    check_frame_a("lone_cfg");
    cfg_req_a = 1'b0;
    repeat (20) step();
    cfg_req_a = 1'b1; cfg_addr_a = 16'h000a; cfg_val_a = 128'h77;
    gv_a = G4;
    sb.push_back('{16'd116, G4, 1'b0});
    sb.push_back('{16'h000a, 128'h77, 1'b1});
    wait_send_a(400, t);
    chk("tie2_goal_at", t, 4147);
    check_frame_a("tie2_goal");
    wait_send_a(400, t);
    chk("tie2_cfg_at", t, 4493);
    check_frame_a("tie2_cfg");
    cfg_req_a = 1'b0;
    sb.push_back('{16'd116, G4, 1'b0});
    wait_send_a(600, t);
    chk("goal5_at", t, 5001);
    check_frame_a("goal5");
    chk("a_no_overrun", a_overrun, 8'd0);

    // Asynchronous reset 100 cycles into WAIT.
    repeat (100) step();
    reset = 1'b1;
    #2;
    chk("async_rst_send_busy_ack", {a_send, a_busy, a_cfg_ack}, 3'b000);
    chk("async_rst_frame", {a_address, a_v4, a_v3, a_v2, a_v1}, '0);
    @(posedge clock);
    #1;
    reset = 1'b0; cyc = 0;
    sb.push_back('{16'd116, G4, 1'b0});
    wait_send_a(1100, t);
    chk("restart_at", t, 1001);
    check_frame_a("restart");

    // Overrun: period 20 against a 346-cycle grant spacing.
    nsend = 0; frame_bad = 0; frozen_bad = 0; dec_bad = 0;
    held_val = '0; held_addr = '0; ov_mid = '0; ov_prev = '0;
    en_b = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      gv_b = {$urandom, $urandom, $urandom, $urandom};
      step();
      if (b_send === 1'b1) begin
        nsend++;
        if ({b_v4, b_v3, b_v2, b_v1} !== gv_b || b_address !== 16'd116 || b_goal_sent !== 1'b1)
          frame_bad++;
        held_val  = {b_v4, b_v3, b_v2, b_v1};
        held_addr = b_address;
      end else if (b_busy === 1'b1) begin
        if ({b_v4, b_v3, b_v2, b_v1} !== held_val || b_address !== held_addr)
          frozen_bad++;
      end
      if (b_overrun < ov_prev) dec_bad++;
      ov_prev = b_overrun;
      if (i == 1500) ov_mid = b_overrun;
    end
    chk("b_frames", frame_bad, 0);
    chk("b_frozen_in_wait", frozen_bad, 0);
    chk("b_send_count_ok", (nsend > 20), 1'b1);
    chk("b_overrun_mid_range", (ov_mid > 8'd0 && ov_mid < 8'd255), 1'b1);
    chk("b_overrun_never_decreases", dec_bad, 0);
    chk("b_overrun_sat", b_overrun, 8'd255);

    // Disabling clears pending: no further goal frames after the current one.
    en_b = 1'b0;
    late_sends = 0;
    for (int i = 0; i < 800; i++) begin
      step();
      if (b_send === 1'b1) late_sends++;
    end
    chk("b_disable_no_send", late_sends, 0);
    chk("b_overrun_hold", b_overrun, 8'd255);
    chk("b_idle_after_disable", b_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
